obstacle_spawner: RTL and testbench
===================================

OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter N_SLOTS, default 3, number of obstacle slots driven.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port enable  input  1  game running; sampled only in IDLE.
REQ-005 SHALL have port update  input  1  one-cycle frame tick.
REQ-006 SHALL have port crash  input  1  game-over pulse.
REQ-007 SHALL have port speed  input  15  horizon speed, scaled by SPEED_SCALE.
REQ-008 SHALL have port rng_data  input  11  free-running random value.
REQ-009 SHALL have port slot_remove  input  N_SLOTS  per-slot remove flag.
REQ-010 SHALL have port slot_gap  input  N_SLOTS x 11  per-slot gap.
REQ-011 SHALL have port slot_x_pos  input  N_SLOTS x 11 signed  per-slot x position.
REQ-012 SHALL have port slot_width  input  N_SLOTS x 10  per-slot width.
REQ-013 SHALL have port slot_start  output  N_SLOTS  per-slot start request.
REQ-014 SHALL have port slot_typ  output  N_SLOTS x type_t  per-slot obstacle type.
REQ-015 SHALL have port active  output  N_SLOTS  slot-occupied flags.

Function
REQ-016 SHALL implement states IDLE, WAIT_TICK, PICK, ARM, CRASHED.
REQ-017 IDLE: enable=1 -> WAIT_TICK next cycle.
REQ-018 WAIT_TICK: on update with spawn_needed and at least one free slot -> PICK; candidate <= (rng_data % 3) + 1; tries <= 0.
REQ-019 spawn_needed SHALL be: no active slot, or newest slot active, not settling, and x_pos + width + gap < GAME_WIDTH, evaluated in 13-bit signed arithmetic.
REQ-020 PICK, legal candidate: target <= lowest-index free slot; slot_typ[target] <= candidate; -> ARM.
REQ-021 PICK, illegal candidate: candidate <= next type (wrap PTERODACTYL -> CACTUS_SMALL); tries++.
REQ-022 PICK with tries=2: SHALL accept CACTUS_SMALL unconditionally.
REQ-023 A candidate SHALL be illegal if PTERODACTYL with speed < MIN_SPEED[PTERODACTYL].
REQ-024 A candidate SHALL be illegal if both history entries equal it (MAX_DUPLICATION=2).
REQ-025 ARM: slot_start[target] SHALL be held 1 until and including the next update cycle.
REQ-026 On that update cycle (start accepted), the block SHALL: set active[target]; set newest <= target; settle[target] <= SETTLE_CYCLES; shift candidate into history; go to WAIT_TICK.
REQ-027 slot_start SHALL drop the cycle after the accepting update.
REQ-028 The accepting update SHALL NOT also trigger a spawn evaluation.
REQ-029 slot_typ[k] SHALL stay stable from PICK until slot k is next reissued; slots keep reading their type while running.
REQ-030 settle[k] SHALL decrement each cycle to 0.
REQ-031 slot_remove[k] SHALL clear active[k] only when settle[k]=0, since a stale remove persists until the slot re-inits.
REQ-032 If remove clears the newest slot, spawn_needed SHALL fall back to the "no active slot" term.
REQ-033 crash in any state SHALL drive the block to CRASHED next cycle and clear all slot_start.
REQ-034 CRASHED SHALL hold slot_typ and active and stay until reset.
REQ-035 crash coincident with the accepting update: CRASHED wins; active is still set.
REQ-036 At most one slot_start bit SHALL be high at any time.

Reset
REQ-037 With rst=0 at a clk edge: state=IDLE, slot_start=0, slot_typ=NONE, active=0, settle=0, history={NONE,NONE}, newest=0, candidate=NONE, tries=0.
REQ-038 Reset mid-ARM SHALL drop slot_start in the same edge.

Structure
REQ-039 spawner_state_t, MAX_DUPLICATION=2 and SETTLE_CYCLES=3 SHALL live in obstacle_pkg.
REQ-040 The block SHALL reuse type_t, MIN_SPEED and GAME_WIDTH from obstacle_pkg.
REQ-041 Legality and next-candidate logic SHALL be one combinational sub-module, obstacle_type_picker.
REQ-042 Slot selection SHALL be a fixed-priority encoder, lowest index first.

Verification
REQ-043 Reset, enable=1, update, rng_data=4 -> slot_typ[0]=CACTUS_LARGE, slot_start[0]=1 until next update, then active=3'b001.
REQ-044 speed=5000, rng_data=2 -> PTERODACTYL rejected, slot_typ=CACTUS_SMALL after 2 PICK cycles.
REQ-045 History {SMALL,SMALL}, rng_data=0, speed=9000 -> CACTUS_LARGE issued.
REQ-046 Newest slot x_pos=500, width=17, gap=130 -> no spawn; x_pos=490 -> spawn into lowest free slot.
REQ-047 slot_remove[0] held high during settle -> active[0] stays 1; at settle=0 remove=1 -> active[0] clears next cycle.
REQ-048 crash during ARM -> slot_start=0 next cycle, state CRASHED, no further starts across 10 updates.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared obstacle types and tuning constants for the obstacle spawner and its
// type picker.
package obstacle_pkg;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        CACTUS_SMALL = 2'd1,
        CACTUS_LARGE = 2'd2,
        PTERODACTYL  = 2'd3
    } type_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        PICK,
        ARM,
        CRASHED
    } spawner_state_t;

    localparam int SPEED_SCALE     = 1000;
    localparam int GAME_WIDTH      = 640;
    localparam int N_TYPES         = 3;
    localparam int MAX_DUPLICATION = 2;
    localparam int SETTLE_CYCLES   = 3;

    // Horizon speed each type needs before it may appear, indexed by type_t.
    localparam logic [14:0] MIN_SPEED [4] = '{15'd0, 15'd0, 15'd0, 15'(7 * SPEED_SCALE)};

    function automatic type_t next_type(input type_t t);
        case (t)
            CACTUS_SMALL: return CACTUS_LARGE;
            CACTUS_LARGE: return PTERODACTYL;
            default:      return CACTUS_SMALL;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_type_picker.sv
// Decides whether the current candidate obstacle type may be issued and which
// type to try next when it may not.
module obstacle_type_picker
    import obstacle_pkg::*;
(
    input  type_t       candidate,
    input  logic [14:0] speed,
    input  type_t       history [MAX_DUPLICATION],
    input  logic [1:0]  tries,
    output logic        accept,
    output type_t       chosen,
    output type_t       next_candidate
);

    logic too_slow;
    logic repeated;

    // After every type has been tried, fall back to the small cactus.
    always_comb begin
        too_slow = (candidate == PTERODACTYL) && (speed < MIN_SPEED[PTERODACTYL]);
        repeated = 1'b1;
        for (int i = 0; i < MAX_DUPLICATION; i++) begin
            if (history[i] != candidate) begin
                repeated = 1'b0;
            end
        end
        if (tries == 2'(N_TYPES - 1)) begin
            accept = 1'b1;
            chosen = CACTUS_SMALL;
        end else begin
            accept = !too_slow && !repeated;
            chosen = candidate;
        end
        next_candidate = next_type(candidate);
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Chooses when to spawn a new obstacle, which type it is and which free slot
// runs it, handshaking with the slots through slot_start/update.
module obstacle_spawner
    import obstacle_pkg::*;
#(
    parameter int N_SLOTS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                update,
    input  logic                crash,
    input  logic [14:0]         speed,
    input  logic [10:0]         rng_data,
    input  logic [N_SLOTS-1:0]  slot_remove,
    input  logic [10:0]         slot_gap   [N_SLOTS],
    input  logic signed [10:0]  slot_x_pos [N_SLOTS],
    input  logic [9:0]          slot_width [N_SLOTS],
    output logic [N_SLOTS-1:0]  slot_start,
    output type_t               slot_typ   [N_SLOTS],
    output logic [N_SLOTS-1:0]  active
);

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic signed [12:0] GAME_EDGE = 13'(GAME_WIDTH);

    spawner_state_t   state;
    logic [IDX_W-1:0] target;
    logic [IDX_W-1:0] newest;
    type_t            candidate;
    logic [1:0]       tries;
    type_t            history [MAX_DUPLICATION];
    logic [SET_W-1:0] settle  [N_SLOTS];

    logic [IDX_W-1:0]  free_idx;
    logic              any_free;
    logic signed [12:0] edge_pos;
    logic              spawn_needed;
    type_t             seed;
    logic              accept;
    type_t             chosen;
    type_t             next_candidate;

    // Lowest-index free slot wins because it is assigned last.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (!active[k]) begin
                free_idx = IDX_W'(k);
                any_free = 1'b1;
            end
        end
    end

    // Trailing edge of the newest obstacle plus its gap, sign-extended to 13 bits.
    always_comb begin
        edge_pos = {{2{slot_x_pos[newest][10]}}, slot_x_pos[newest]}
                 + {3'b000, slot_width[newest]}
                 + {2'b00, slot_gap[newest]};
        spawn_needed = (active == '0)
                    || (active[newest] && (settle[newest] == '0) && (edge_pos < GAME_EDGE));
        seed = type_t'(2'(rng_data % 11'd3) + 2'd1);
    end

    obstacle_type_picker u_picker (
        .candidate      (candidate),
        .speed          (speed),
        .history        (history),
        .tries          (tries),
        .accept         (accept),
        .chosen         (chosen),
        .next_candidate (next_candidate)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            slot_start <= '0;
            active     <= '0;
            target     <= '0;
            newest     <= '0;
            candidate  <= NONE;
            tries      <= '0;
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_typ[k] <= NONE;
                settle[k]   <= '0;
            end
            for (int i = 0; i < MAX_DUPLICATION; i++) begin
                history[i] <= NONE;
            end
        end else begin
            for (int k = 0; k < N_SLOTS; k++) begin
                if (settle[k] != '0) begin
                    settle[k] <= settle[k] - 1'b1;
                end
            end

            // A remove left over from the slot's previous run is ignored while it settles.
            if (state != CRASHED) begin
                for (int k = 0; k < N_SLOTS; k++) begin
                    if (slot_remove[k] && (settle[k] == '0)) begin
                        active[k] <= 1'b0;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (update && spawn_needed && any_free) begin
                        candidate <= seed;
                        tries     <= '0;
                        state     <= PICK;
                    end
                end
                PICK: begin
                    if (accept) begin
                        target             <= free_idx;
                        slot_typ[free_idx] <= chosen;
                        candidate          <= chosen;
                        for (int k = 0; k < N_SLOTS; k++) begin
                            slot_start[k] <= (IDX_W'(k) == free_idx);
                        end
                        state <= ARM;
                    end else begin
                        candidate <= next_candidate;
                        tries     <= tries + 2'd1;
                    end
                end
                ARM: begin
                    if (update) begin
                        active[target] <= 1'b1;
                        newest         <= target;
                        settle[target] <= SET_W'(SETTLE_CYCLES);
                        history[0]     <= candidate;
                        for (int i = 1; i < MAX_DUPLICATION; i++) begin
                            history[i] <= history[i-1];
                        end
                        slot_start <= '0;
                        state      <= WAIT_TICK;
                    end
                end
                CRASHED: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (crash) begin
                state      <= CRASHED;
                slot_start <= '0;
            end
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: table of spawn vectors plus hand
// sequences, with a scoreboard queue checked whenever a slot_start rises.
module tb_obstacle_spawner;
    import obstacle_pkg::*;

    localparam int NS = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enable = 1'b0;
    logic               update = 1'b0;
    logic               crash = 1'b0;
    logic [14:0]        speed = '0;
    logic [10:0]        rng_data = '0;
    logic [NS-1:0]      slot_remove = '0;
    logic [10:0]        slot_gap   [NS];
    logic signed [10:0] slot_x_pos [NS];
    logic [9:0]         slot_width [NS];
    logic [NS-1:0]      slot_start;
    type_t              slot_typ   [NS];
    logic [NS-1:0]      active;

    typedef struct {
        int    slot;
        type_t typ;
    } exp_t;

    typedef struct {
        logic [NS-1:0] remove;
        logic [14:0]   speed;
        logic [10:0]   rng;
        int            slot;
        type_t         typ;
        int            picks;
    } vec_t;

    exp_t          exp_q [$];
    exp_t          popped;
    vec_t          vecs [11];
    logic [NS-1:0] exp_active;
    logic [NS-1:0] prev_start = '0;
    int            total = 0;
    int            bad = 0;
    int            n;

    obstacle_spawner #(.N_SLOTS(NS)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .update      (update),
        .crash       (crash),
        .speed       (speed),
        .rng_data    (rng_data),
        .slot_remove (slot_remove),
        .slot_gap    (slot_gap),
        .slot_x_pos  (slot_x_pos),
        .slot_width  (slot_width),
        .slot_start  (slot_start),
        .slot_typ    (slot_typ),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every rising slot_start must match the oldest queued expectation.
    always @(negedge clk) begin
        if (slot_start != '0 && prev_start == '0) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_start", 32'(slot_start), 32'd0);
            end else begin
                popped = exp_q.pop_front();
                check_output("start_slot", 32'(slot_start), 32'(1 << popped.slot));
                check_output("start_type", 32'(slot_typ[popped.slot]), 32'(popped.typ));
            end
        end
        if (slot_start != '0) begin
            check_output("start_onehot", 32'($onehot(slot_start)), 32'd1);
        end
        prev_start = slot_start;
    end

    task automatic do_reset();
        rst         = 1'b0;
        enable      = 1'b0;
        update      = 1'b0;
        crash       = 1'b0;
        slot_remove = '0;
        repeat (2) tick();
        rst        = 1'b1;
        exp_active = '0;
    endtask

    task automatic start_game();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_start(output int cycles);
        cycles = 0;
        while (slot_start == '0 && cycles < 10) begin
            tick();
            cycles++;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int c;
        if (v.remove != '0) begin
            slot_remove = v.remove;
            tick();
            slot_remove = '0;
            exp_active &= ~v.remove;
            check_output("remove_active", 32'(active), 32'(exp_active));
        end
        speed    = v.speed;
        rng_data = v.rng;
        exp_q.push_back('{v.slot, v.typ});
        pulse_update();
        wait_start(c);
        check_output("pick_cycles", 32'(c), 32'(v.picks));
        repeat (2) begin
            tick();
            check_output("start_held", 32'(slot_start), 32'(1 << v.slot));
        end
        pulse_update();
        check_output("start_drop", 32'(slot_start), 32'd0);
        exp_active |= NS'(1 << v.slot);
        check_output("active_set", 32'(active), 32'(exp_active));
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 15'd0,    11'd4, 0, CACTUS_LARGE, 1};
        vecs[1]  = '{3'b000, 15'd5000, 11'd2, 1, CACTUS_SMALL, 2};
        vecs[2]  = '{3'b000, 15'd5000, 11'd0, 2, CACTUS_SMALL, 1};
        vecs[3]  = '{3'b001, 15'd9000, 11'd0, 0, CACTUS_LARGE, 2};
        vecs[4]  = '{3'b010, 15'd9000, 11'd2, 1, PTERODACTYL,  1};
        vecs[5]  = '{3'b100, 15'd100,  11'd1, 2, CACTUS_LARGE, 1};
        vecs[6]  = '{3'b001, 15'd100,  11'd5, 0, CACTUS_SMALL, 2};
        vecs[7]  = '{3'b010, 15'd100,  11'd1, 1, CACTUS_LARGE, 1};
        vecs[8]  = '{3'b100, 15'd100,  11'd7, 2, CACTUS_LARGE, 1};
        vecs[9]  = '{3'b001, 15'd100,  11'd1, 0, CACTUS_SMALL, 3};
        vecs[10] = '{3'b110, 15'd9000, 11'd3, 1, CACTUS_SMALL, 1};

        for (int k = 0; k < NS; k++) begin
            slot_gap[k]   = '0;
            slot_x_pos[k] = '0;
            slot_width[k] = '0;
        end

        do_reset();
        check_output("reset_start", 32'(slot_start), 32'd0);
        check_output("reset_active", 32'(active), 32'd0);
        for (int k = 0; k < NS; k++) begin
            check_output("reset_typ", 32'(slot_typ[k]), 32'(NONE));
        end

        start_game();
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Newest obstacle (slot 1) still too far right: no spawn.
        slot_x_pos[1] = 11'sd500;
        slot_width[1] = 10'd17;
        slot_gap[1]   = 11'd130;
        speed         = 15'd0;
        rng_data      = 11'd4;
        pulse_update();
        repeat (5) tick();
        check_output("no_spawn_far", 32'(slot_start), 32'd0);

        // Once it has moved left enough the spawn goes to the lowest free slot.
        slot_x_pos[1] = 11'sd490;
        exp_q.push_back('{2, CACTUS_LARGE});
        pulse_update();
        wait_start(n);
        check_output("near_pick_cycles", 32'(n), 32'd1);
        pulse_update();
        check_output("near_active", 32'(active), 32'b111);

        // Remove held through settle is ignored until settle reaches zero.
        slot_remove = 3'b100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("settle_hold", 32'(active), 32'b111);
        end
        tick();
        check_output("settle_clear", 32'(active), 32'b011);
        slot_remove = '0;
        exp_active  = 3'b011;

        // Newest slot removed while others are active: no spawn.
        for (int k = 0; k < NS; k++) begin
            slot_x_pos[k] = '0;
            slot_width[k] = '0;
            slot_gap[k]   = '0;
        end
        pulse_update();
        repeat (5) tick();
        check_output("no_spawn_newest_gone", 32'(slot_start), 32'd0);
        apply_stimulus('{3'b011, 15'd0, 11'd0, 0, CACTUS_SMALL, 1});

        // Reset while armed drops slot_start at the same edge.
        do_reset();
        start_game();
        rng_data = 11'd4;
        exp_q.push_back('{0, CACTUS_LARGE});
        pulse_update();
        wait_start(n);
        check_output("arm_before_reset", 32'(slot_start), 32'b001);
        rst = 1'b0;
        tick();
        check_output("reset_arm_start", 32'(slot_start), 32'd0);
        check_output("reset_arm_typ", 32'(slot_typ[0]), 32'(NONE));
        rst = 1'b1;

        // Crash while armed: start drops and nothing spawns afterwards.
        start_game();
        exp_q.push_back('{0, CACTUS_LARGE});
        pulse_update();
        wait_start(n);
        crash = 1'b1;
        tick();
        crash = 1'b0;
        check_output("crash_start", 32'(slot_start), 32'd0);
        for (int i = 0; i < 10; i++) begin
            pulse_update();
            tick();
            check_output("crash_no_start", 32'(slot_start), 32'd0);
        end
        check_output("crash_active", 32'(active), 32'd0);
        check_output("crash_typ_held", 32'(slot_typ[0]), 32'(CACTUS_LARGE));

        check_output("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
